seq_rotate_shift: RTL and testbench
===================================

Name: seq_rotate_shift

Overview:
Parametrised, multi-cycle rotate/shift unit and the successor to the fixed 4-bit combinational rotators. It accepts a WIDTH-bit operand, an operation code and a shift amount over a valid/ready handshake. It shifts by up to STEP bits per clock under a small FSM, then returns the result over a second valid/ready handshake. It trades latency for area and sits in front of the datapath shifter slot of the ALU exercises.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, at least 4.
STEP, 1, maximum bits shifted per cycle; power of two, 1 <= STEP <= WIDTH.
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  request present
in_ready  output  1  unit can accept a request
in_data  input  WIDTH  operand
in_op  input  3  operation (see package)
in_shamt  input  SHW  shift amount 0..WIDTH-1
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  result
out_err  output  1  reserved op flagged; valid with out_valid
busy  output  1  FSM not in IDLE

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n); all state resets on reset_n low, independent of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, busy=0, internal data/remaining/op registers=0.
- Ops: 000 ROR, 001 ROL, 010 SLL (zero fill), 011 SRL (zero fill), 100 SRA (MSB fill). Codes 101..111 are reserved: the operand passes through unshifted, remaining is forced to 0, and out_err=1.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1. When in_valid is high, capture data, op and shamt, and set remaining=shamt. Go to BUSY if shamt!=0 and op is legal; otherwise go to DONE. in_* is ignored outside IDLE.
  - BUSY: each cycle apply k=min(STEP, remaining) bits of the captured op to the data register, then remaining -= k. When the post-update remaining is 0, go to DONE.
  - DONE: out_valid=1, out_data=data register, out_err=captured flag; all held stable until out_ready is high. On out_valid&&out_ready, go to IDLE and clear out_valid/out_err; out_data keeps its last value.
- Latency: out_valid rises ceil(shamt/STEP)+1 rising edges after the accepting edge; shamt=0 gives 1 edge.
- Throughput: one request in flight. in_ready is low in BUSY and DONE, so there is no back-to-back accept in the same cycle as a result handoff.
- Cumulative partial steps equal a single shift of shamt: rotates wrap modulo WIDTH, and SRA keeps replicating the original MSB across steps.
- out_ready held low in DONE: the FSM stalls indefinitely with outputs stable.
- out_ready high outside DONE: no effect.
- reset_n asserted mid-BUSY or mid-DONE: immediate return to reset values; the partial result is discarded and no out_valid pulse occurs.
- Width rules: shamt is unsigned SHW bits; the remaining counter is SHW bits and never underflows.

Decomposition:
- Package seq_rotate_shift_pkg: op enum (OP_ROR, OP_ROL, OP_SLL, OP_SRL, OP_SRA), FSM state enum (S_IDLE, S_BUSY, S_DONE), and a function is_legal_op.
- Sub-module rot_step: combinational, parametrised by WIDTH/STEP. Applies a k-bit (0..STEP) shift of the given op to a WIDTH-bit value. It is the only shifting logic; the top level holds the FSM, counter and handshake.

Test Plan:
- WIDTH=8, STEP=1: ROR 0x96 by 3 -> out_data=0xD2, out_err=0, out_valid 4 edges after accept.
- WIDTH=8, STEP=1: ROL 0x96 by 1 -> 0x2D; SLL by 3 -> 0xB0; SRL by 3 -> 0x12; SRA by 3 -> 0xF2.
- WIDTH=8, STEP=4: ROR 0x96 by 7 -> 0x2D after 3 edges; shamt=0, op SRA -> 0x96 after 1 edge.
- Backpressure: out_ready low for 5 cycles in DONE -> out_valid/out_data/out_err stable, in_ready=0; then out_ready=1 -> IDLE next edge, in_ready=1.
- Reserved op 110, data 0x5A, shamt 5 -> out_data=0x5A, out_err=1 after 1 edge.
- reset_n pulsed low during BUSY (WIDTH=8, STEP=1, shamt=7) -> asynchronous return to IDLE, out_valid never asserts, in_ready=1, out_data=0.

Source files
------------

// File: rtl/seq_rotate_shift_pkg.sv
// Shared types for the multi-cycle rotate/shift unit: op codes, FSM states
// and the legality check for the op field.
package seq_rotate_shift_pkg;

  typedef enum logic [2:0] {
    OP_ROR = 3'b000,
    OP_ROL = 3'b001,
    OP_SLL = 3'b010,
    OP_SRL = 3'b011,
    OP_SRA = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= 3'b100;
  endfunction

endpackage

// File: rtl/seq_rotate_shift_if.sv
// Request/response handshake bundle for seq_rotate_shift; the unit is the
// slave, the requester/consumer is the master.
interface seq_rotate_shift_if #(parameter int WIDTH = 8);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic [SHW-1:0]   in_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             busy;

  modport slave (
    input  in_valid, in_data, in_op, in_shamt, out_ready,
    output in_ready, out_valid, out_data, out_err, busy
  );

  modport master (
    output in_valid, in_data, in_op, in_shamt, out_ready,
    input  in_ready, out_valid, out_data, out_err, busy
  );
endinterface

// File: rtl/seq_rotate_shift_step.sv
// Combinational k-bit (0..STEP) shift/rotate of one WIDTH-bit value; the
// only shifting logic in the unit. Reserved ops pass the value through.
module rot_step
  import seq_rotate_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] val,
  input  logic [2:0]       op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] res
);
  logic [2*WIDTH-1:0] dbl;
  assign dbl = {val, val};

  // Rotates slide a window over the doubled operand so k=0 needs no special case.
  always_comb begin
    res = val;
    case (op)
      OP_ROR:  res = WIDTH'(dbl >> k);
      OP_ROL:  res = WIDTH'((dbl << k) >> WIDTH);
      OP_SLL:  res = val << k;
      OP_SRL:  res = val >> k;
      OP_SRA:  res = $signed(val) >>> k;
      default: res = val;
    endcase
  end
endmodule

// File: rtl/seq_rotate_shift.sv
// Multi-cycle rotate/shift unit: captures a request, applies up to STEP bits
// per clock through rot_step, then holds the result until it is taken.
module seq_rotate_shift
  import seq_rotate_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  seq_rotate_shift_if.slave io
);
  localparam int SHW = $clog2(WIDTH);
  localparam int KW  = $clog2(STEP + 1);

  state_e           state, state_nx;
  logic [WIDTH-1:0] data_q, res_q, step_val;
  logic [2:0]       op_q;
  logic [SHW-1:0]   rem_q, rem_nx;
  logic             err_q;
  logic [KW-1:0]    k;
  logic             legal;

  assign legal = is_legal_op(io.in_op);

  // k = min(STEP, remaining); compared at 32 bits since STEP may equal WIDTH.
  always_comb begin
    if (32'(rem_q) >= STEP) k = KW'(STEP);
    else                    k = KW'(rem_q);
  end
  assign rem_nx = rem_q - SHW'(k);

  rot_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .val(data_q), .op(op_q), .k(k), .res(step_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (io.in_valid)
                 state_nx = (io.in_shamt != '0 && legal) ? S_BUSY : S_DONE;
      S_BUSY:  if (rem_nx == '0) state_nx = S_DONE;
      S_DONE:  if (io.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = (state == S_IDLE);
    io.busy      = (state != S_IDLE);
    io.out_valid = (state == S_DONE);
    io.out_err   = (state == S_DONE) && err_q;
    io.out_data  = res_q;
  end

  // res_q is loaded only on entry to DONE so the last result survives IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      res_q  <= '0;
      op_q   <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (io.in_valid) begin
          data_q <= io.in_data;
          op_q   <= io.in_op;
          err_q  <= !legal;
          rem_q  <= legal ? io.in_shamt : '0;
          if (!legal || io.in_shamt == '0) res_q <= io.in_data;
        end
        S_BUSY: begin
          data_q <= step_val;
          rem_q  <= rem_nx;
          if (rem_nx == '0) res_q <= step_val;
        end
        S_DONE: if (io.out_ready) err_q <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_rotate_shift.sv
// Directed bench for seq_rotate_shift at STEP=1 and STEP=4 with a result
// scoreboard (data, err flag, edges from accept to out_valid).
module tb_seq_rotate_shift;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_rotate_shift_if #(.WIDTH(8)) ifa ();
  seq_rotate_shift_if #(.WIDTH(8)) ifb ();

  seq_rotate_shift #(.WIDTH(8), .STEP(1)) ua (.clk(clk), .reset_n(reset_n), .io(ifa));
  seq_rotate_shift #(.WIDTH(8), .STEP(4)) ub (.clk(clk), .reset_n(reset_n), .io(ifb));

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ov(input bit sel);
    return sel ? ifb.out_valid : ifa.out_valid;
  endfunction
  function automatic logic [7:0] od(input bit sel);
    return sel ? ifb.out_data : ifa.out_data;
  endfunction
  function automatic logic oe(input bit sel);
    return sel ? ifb.out_err : ifa.out_err;
  endfunction
  function automatic logic ir(input bit sel);
    return sel ? ifb.in_ready : ifa.in_ready;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [2:0] op,
                       input logic [7:0] d, input logic [2:0] sh, input logic rdy);
    if (sel) begin
      ifb.in_valid = v; ifb.in_op = op; ifb.in_data = d; ifb.in_shamt = sh; ifb.out_ready = rdy;
    end else begin
      ifa.in_valid = v; ifa.in_op = op; ifa.in_data = d; ifa.in_shamt = sh; ifa.out_ready = rdy;
    end
  endtask

  task automatic do_req(input bit sel, input logic [2:0] op, input logic [7:0] d,
                        input logic [2:0] sh, input logic [7:0] xd, input logic xe,
                        input int xlat, input int hold);
    int lat;
    exp_t e;
    @(negedge clk);
    drive(sel, 1'b1, op, d, sh, 1'b0);
    chk("in_ready_idle", ir(sel), 1'b1);
    sb.push_back('{d: xd, e: xe, lat: xlat});
    @(posedge clk); #1;
    drive(sel, 1'b0, 3'b000, 8'h00, 3'd0, 1'b0);
    lat = 1;
    while (!ov(sel) && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk("out_valid_seen", ov(sel), 1'b1);
    chk("out_data", od(sel), e.d);
    chk("out_err", oe(sel), e.e);
    chk("latency", lat, e.lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", ov(sel), 1'b1);
      chk("stall_data", od(sel), e.d);
      chk("stall_err", oe(sel), e.e);
      chk("stall_in_ready", ir(sel), 1'b0);
    end
    @(negedge clk);
    drive(sel, 1'b0, 3'b000, 8'h00, 3'd0, 1'b1);
    @(posedge clk); #1;
    chk("handoff_valid_low", ov(sel), 1'b0);
    chk("handoff_in_ready", ir(sel), 1'b1);
    chk("handoff_err_low", oe(sel), 1'b0);
    drive(sel, 1'b0, 3'b000, 8'h00, 3'd0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 3'b000, 8'h00, 3'd0, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 8'h00, 3'd0, 1'b0);
    #12;
    chk("rst_in_ready", ifa.in_ready, 1'b1);
    chk("rst_out_valid", ifa.out_valid, 1'b0);
    chk("rst_out_data", ifa.out_data, 8'h00);
    chk("rst_out_err", ifa.out_err, 1'b0);
    chk("rst_busy", ifa.busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // STEP=1 ops
    do_req(1'b0, 3'b000, 8'h96, 3'd3, 8'hD2, 1'b0, 4, 0);
    do_req(1'b0, 3'b001, 8'h96, 3'd1, 8'h2D, 1'b0, 2, 0);
    do_req(1'b0, 3'b010, 8'h96, 3'd3, 8'hB0, 1'b0, 4, 0);
    do_req(1'b0, 3'b011, 8'h96, 3'd3, 8'h12, 1'b0, 4, 0);
    do_req(1'b0, 3'b100, 8'h96, 3'd3, 8'hF2, 1'b0, 4, 5);
    do_req(1'b0, 3'b110, 8'h5A, 3'd5, 8'h5A, 1'b1, 1, 0);

    // STEP=4: multi-bit steps with a partial final step
    do_req(1'b1, 3'b000, 8'h96, 3'd7, 8'h2D, 1'b0, 3, 0);
    do_req(1'b1, 3'b100, 8'h96, 3'd0, 8'h96, 1'b0, 1, 0);
    do_req(1'b1, 3'b100, 8'h96, 3'd7, 8'hFF, 1'b0, 3, 0);
    do_req(1'b1, 3'b001, 8'h81, 3'd5, 8'h30, 1'b0, 3, 0);

    // async reset mid-BUSY discards the partial result
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 8'h96, 3'd7, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 8'h00, 3'd0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("pre_rst_busy", ifa.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("arst_in_ready", ifa.in_ready, 1'b1);
    chk("arst_busy", ifa.busy, 1'b0);
    chk("arst_out_valid", ifa.out_valid, 1'b0);
    chk("arst_out_data", ifa.out_data, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", ifa.out_valid, 1'b0);
    end
    chk("post_rst_in_ready", ifa.in_ready, 1'b1);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
